ascon_fsm_ctrl: RTL

Moore-style sequencer for the ASCON-128a `permutation_finale` datapath. It drives the round index, the XOR and capture enables, and the input mux so that one message is processed in order: initialization, then NB_AD associated-data blocks, then NB_PT plaintext blocks with tag generation on the last one. The block sits between the top-level I/O handshake and `permutation_finale`; key, nonce and data buses go straight to the datapath and are not routed through this block.

---
 rtl/ascon_fsm_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ascon_fsm_ctrl.sv
// rtl/ascon_fsm_ctrl.sv - Moore sequencer for the ASCON-128a permutation_finale datapath
// Optional status outputs (state_o, block_cnt_o, error_o) are built when ASCON_FSM_STATUS_EN is defined.
module ascon_fsm_ctrl #(
  parameter int NB_AD = 1,
  parameter int NB_PT = 3
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       en_o,
  output logic       input_mod_o,
  output logic [3:0] round_o,
  output logic       en_xor_data_o,
  output logic       en_xor_begin_key_o,
  output logic       en_xor_lsb_o,
  output logic       en_xor_end_key_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       cipher_valid_o,
  output logic       done_o,
  output logic       busy_o
`ifdef ASCON_FSM_STATUS_EN
  ,
  output logic [2:0] state_o,
  output logic [3:0] block_cnt_o,
  output logic       error_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_AD_WAIT, S_AD, S_PT_WAIT, S_PT, S_FINAL, S_DONE
  } state_t;

  // Index of the last AD / PT block; LAST_AD is unused when there is no AD.
  localparam logic [3:0] LAST_AD = (NB_AD > 0) ? 4'(NB_AD - 1) : 4'd0;
  localparam logic [3:0] LAST_PT = 4'(NB_PT - 1);
  localparam bit         HAS_AD  = (NB_AD > 0);

  state_t     r_state;
  logic [3:0] r_rc;
  logic [3:0] r_bc;
  logic       r_cipher_valid;
  logic       r_done;

  logic       w_data_ready;
  logic       w_en;
  logic       w_input_mod;
  logic [3:0] w_round;
  logic       w_xor_data;
  logic       w_xor_begin_key;
  logic       w_xor_lsb;
  logic       w_xor_end_key;
  logic       w_en_cipher;
  logic       w_en_tag;
  logic       w_busy;
  logic       w_accept;
  logic       w_last_round;

  assign w_last_round = (r_rc == 4'd11);
  assign w_accept     = data_valid_i && w_data_ready;

  // Sequencer: state, round/block counters and the two delayed valid pulses.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      r_state        <= S_IDLE;
      r_rc           <= 4'd0;
      r_bc           <= 4'd0;
      r_cipher_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_cipher_valid <= w_en_cipher;
      r_done         <= w_en_tag;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_INIT;
            r_rc    <= 4'd0;
            r_bc    <= 4'd0;
          end
        end
        S_INIT: begin
          if (w_last_round) r_state <= HAS_AD ? S_AD_WAIT : S_PT_WAIT;
          else              r_rc    <= r_rc + 4'd1;
        end
        S_AD_WAIT: begin
          if (w_accept) begin
            r_state <= S_AD;
            r_rc    <= 4'd4;
          end
        end
        S_AD: begin
          if (w_last_round) begin
            // Block counter restarts for the plaintext phase after the last AD block.
            if (r_bc == LAST_AD) begin
              r_bc    <= 4'd0;
              r_state <= S_PT_WAIT;
            end else begin
              r_bc    <= r_bc + 4'd1;
              r_state <= S_AD_WAIT;
            end
          end else begin
            r_rc <= r_rc + 4'd1;
          end
        end
        S_PT_WAIT: begin
          if (w_accept) begin
            if (r_bc == LAST_PT) begin
              r_state <= S_FINAL;
              r_rc    <= 4'd0;
            end else begin
              r_state <= S_PT;
              r_rc    <= 4'd4;
            end
          end
        end
        S_PT: begin
          if (w_last_round) begin
            r_bc    <= r_bc + 4'd1;
            r_state <= S_PT_WAIT;
          end else begin
            r_rc <= r_rc + 4'd1;
          end
        end
        S_FINAL: begin
          if (w_last_round) begin
            r_state <= S_DONE;
            r_rc    <= 4'd0;
          end else begin
            r_rc <= r_rc + 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath controls decoded from state and round counter with no added latency.
  always_comb begin
    w_data_ready    = 1'b0;
    w_en            = 1'b0;
    w_input_mod     = 1'b0;
    w_round         = 4'd0;
    w_xor_data      = 1'b0;
    w_xor_begin_key = 1'b0;
    w_xor_lsb       = 1'b0;
    w_xor_end_key   = 1'b0;
    w_en_cipher     = 1'b0;
    w_en_tag        = 1'b0;
    w_busy          = (r_state != S_IDLE);
    case (r_state)
      S_INIT: begin
        w_en          = 1'b1;
        w_input_mod   = (r_rc != 4'd0);
        w_round       = r_rc;
        w_xor_end_key = w_last_round;
        w_xor_lsb     = w_last_round && !HAS_AD;
      end
      S_AD_WAIT, S_PT_WAIT: begin
        // Datapath holds; round_o keeps the counter value so it stays stable while waiting.
        w_data_ready = 1'b1;
        w_input_mod  = 1'b1;
        w_round      = r_rc;
      end
      S_AD: begin
        w_en        = 1'b1;
        w_input_mod = 1'b1;
        w_round     = r_rc;
        w_xor_data  = (r_rc == 4'd4);
        w_xor_lsb   = w_last_round && (r_bc == LAST_AD);
      end
      S_PT: begin
        w_en        = 1'b1;
        w_input_mod = 1'b1;
        w_round     = r_rc;
        w_xor_data  = (r_rc == 4'd4);
        w_en_cipher = (r_rc == 4'd4);
      end
      S_FINAL: begin
        w_en            = 1'b1;
        w_input_mod     = 1'b1;
        w_round         = r_rc;
        w_xor_data      = (r_rc == 4'd0);
        w_en_cipher     = (r_rc == 4'd0);
        w_xor_begin_key = (r_rc == 4'd0);
        w_xor_end_key   = w_last_round;
        w_en_tag        = w_last_round;
      end
      default: ;
    endcase
  end

  assign data_ready_o       = w_data_ready;
  assign en_o               = w_en;
  assign input_mod_o        = w_input_mod;
  assign round_o            = w_round;
  assign en_xor_data_o      = w_xor_data;
  assign en_xor_begin_key_o = w_xor_begin_key;
  assign en_xor_lsb_o       = w_xor_lsb;
  assign en_xor_end_key_o   = w_xor_end_key;
  assign en_cipher_o        = w_en_cipher;
  assign en_tag_o           = w_en_tag;
  assign cipher_valid_o     = r_cipher_valid;
  assign done_o             = r_done;
  assign busy_o             = w_busy;

`ifdef ASCON_FSM_STATUS_EN
  logic r_error;
  logic w_bad_valid;

  assign w_bad_valid = data_valid_i &&
                       ((r_state == S_INIT) || (r_state == S_AD) ||
                        (r_state == S_PT)   || (r_state == S_FINAL));

  // Sticky protocol-violation flag; only reset clears it.
  always_ff @(posedge clock_i) begin
    if (!resetb_i)                                   r_error <= 1'b0;
    else if ((start_i && w_busy) || w_bad_valid)     r_error <= 1'b1;
  end

  assign state_o     = r_state;
  assign block_cnt_o = r_bc;
  assign error_o     = r_error;
`endif

endmodule
